// File: rtl/hex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_pkg
// Description : Shared constants for the HEX segment driver: register map
//               addresses and CTRL register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_pkg;

   // Register map (2-bit word address)
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_BRIGHT = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // CTRL register bit indices
   localparam int CTRL_EN    = 0;
   localparam int CTRL_BLINK = 1;
   localparam int CTRL_INV   = 2;

endpackage
`default_nettype wire

// File: rtl/hex_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : hex_tick_div
// Description : Free-running wrap counter 0..DIV-1 with a one-cycle pulse
//               while the count sits at DIV-1.
// Ports       : clk     - system clock
//               reset_n - asynchronous active-low reset
//               pulse   - high for one cycle every DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
module hex_tick_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   output logic pulse
);

   // DIV = 1 still gets a 1-bit counter that stays at 0, so pulse is constant.
   localparam int             W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]   C_LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign pulse = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/hex_seg_driver.sv
`default_nettype none
// ============================================================================
// Module      : hex_seg_driver
// Description : Avalon-MM configurable pin driver for one 7-segment HEX digit.
//               Registers the upstream PIO pattern and applies enable, blink,
//               16-level PWM dimming and output polarity.
// Ports       : clk, reset_n            - clock, async active-low reset
//               address, chipselect,
//               write_n, writedata      - register slave write side
//               readdata                - combinational read data
//               seg_in                  - segment pattern, bit0 = segment a
//               hex_n                   - registered segment pins
// Revision    : 1.0 - initial release
// ============================================================================
module hex_seg_driver
   import hex_pkg::*;
#(
   parameter int         TICK_DIV  = 50000,
   parameter int         PWM_DIV   = 64,
   parameter logic [7:0] BLINK_DEF = 8'd250
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [6:0]  seg_in,
   output logic [6:0]  hex_n
);

   logic        w_wr;
   logic        w_tick;
   logic        w_pwm_step;
   logic [7:0]  w_blink_last;
   logic        w_pwm_on;
   logic        w_lit;
   logic [6:0]  w_act;
   logic        w_unused;

   logic [2:0]  r_ctrl;
   logic [3:0]  r_duty;
   logic [7:0]  r_blink_div;
   logic [6:0]  r_seg_q;
   logic [7:0]  r_blink_cnt;
   logic        r_blink_phase;
   logic [3:0]  r_pwm_cnt;
   logic [6:0]  r_hex_n;

   assign w_wr     = chipselect & ~write_n;
   assign w_unused = ^writedata[31:8];

   hex_tick_div #(.DIV(TICK_DIV)) u_tick_div (
      .clk     (clk),
      .reset_n (reset_n),
      .pulse   (w_tick)
   );

   hex_tick_div #(.DIV(PWM_DIV)) u_pwm_div (
      .clk     (clk),
      .reset_n (reset_n),
      .pulse   (w_pwm_step)
   );

   // Configuration registers; STATUS is read-only so writes to it fall through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl      <= 3'b101;
         r_duty      <= 4'hF;
         r_blink_div <= BLINK_DEF;
      end else if (w_wr) begin
         case (address)
            ADDR_CTRL:   r_ctrl      <= writedata[2:0];
            ADDR_BRIGHT: r_duty      <= writedata[3:0];
            ADDR_BLINK:  r_blink_div <= writedata[7:0];
            default:     ;
         endcase
      end
   end

   // Input pipeline stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seg_q <= 7'h00;
      end else begin
         r_seg_q <= seg_in;
      end
   end

   // A divider of 0 is treated as 1, so the terminal count is 0 in both cases.
   assign w_blink_last = (r_blink_div == 8'd0) ? 8'd0 : (r_blink_div - 8'd1);

   // A BLINK_DIV write restarts the half-period in the visible phase and wins
   // over a tick landing in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_cnt   <= 8'd0;
         r_blink_phase <= 1'b1;
      end else if (w_wr && (address == ADDR_BLINK)) begin
         r_blink_cnt   <= 8'd0;
         r_blink_phase <= 1'b1;
      end else if (w_tick) begin
         if (r_blink_cnt >= w_blink_last) begin
            r_blink_cnt   <= 8'd0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_cnt <= 4'd0;
      end else if (w_pwm_step) begin
         r_pwm_cnt <= r_pwm_cnt + 4'd1;
      end
   end

   // Duty 15 is forced fully on; otherwise the 16-step ramp would leave a gap.
   assign w_pwm_on = (r_duty == 4'hF) | (r_pwm_cnt < r_duty);
   assign w_lit    = r_ctrl[CTRL_EN] & w_pwm_on &
                     (~r_ctrl[CTRL_BLINK] | r_blink_phase);
   assign w_act    = w_lit ? r_seg_q : 7'h00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hex_n <= 7'h7F;
      end else begin
         r_hex_n <= r_ctrl[CTRL_INV] ? ~w_act : w_act;
      end
   end

   assign hex_n = r_hex_n;

   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_CTRL:   readdata[2:0] = r_ctrl;
         ADDR_BRIGHT: readdata[3:0] = r_duty;
         ADDR_BLINK:  readdata[7:0] = r_blink_div;
         ADDR_STATUS: begin
            readdata[6:0] = r_seg_q;
            readdata[8]   = r_blink_phase;
            readdata[9]   = w_pwm_on;
         end
         default:     readdata = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_hex_seg_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_seg_driver
// Description : Self-checking bench for hex_seg_driver with a cycle-count
//               based reference model (TICK_DIV=4, PWM_DIV=1, BLINK_DEF=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_seg_driver;

   localparam int TICK = 4;
   localparam int PWMD = 1;
   localparam int BDEF = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [6:0]  seg_in;
   logic [6:0]  hex_n;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   hex_seg_driver #(
      .TICK_DIV  (TICK),
      .PWM_DIV   (PWMD),
      .BLINK_DEF (8'(BDEF))
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .seg_in     (seg_in),
      .hex_n      (hex_n)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // m_k: cycles since reset release; m_ts: blink ticks since last BLINK_DIV
   // write. Prescalers, PWM position and blink phase all follow from these.
   int         m_k;
   int         m_ts;
   logic [2:0] m_ctrl;
   logic [3:0] m_duty;
   logic [7:0] m_div;
   logic [6:0] m_segq;
   logic [6:0] m_hex;

   function automatic bit m_phase();
      int dv;
      dv = (m_div == 8'd0) ? 1 : int'(m_div);
      return ((m_ts / dv) % 2) == 0;
   endfunction

   function automatic bit m_pwm_on();
      int pc;
      pc = (m_k / PWMD) % 16;
      return (m_duty == 4'd15) || (pc < int'(m_duty));
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {29'd0, m_ctrl};
         2'd1:    return {28'd0, m_duty};
         2'd2:    return {24'd0, m_div};
         default: return {22'd0, m_pwm_on(), m_phase(), 1'b0, m_segq};
      endcase
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit         tk;
      bit         lit;
      bit         bwr;
      logic [6:0] act;
      if (!reset_n) begin
         m_k    = 0;
         m_ts   = 0;
         m_ctrl = 3'd5;
         m_duty = 4'd15;
         m_div  = 8'(BDEF);
         m_segq = 7'd0;
         m_hex  = 7'h7F;
      end else begin
         tk    = (m_k % TICK) == (TICK - 1);
         lit   = m_ctrl[0] && m_pwm_on() && (!m_ctrl[1] || m_phase());
         act   = lit ? m_segq : 7'd0;
         m_hex = m_ctrl[2] ? ~act : act;
         bwr   = 1'b0;
         if (chipselect && !write_n) begin
            case (address)
               2'd0: m_ctrl = writedata[2:0];
               2'd1: m_duty = writedata[3:0];
               2'd2: begin m_div = writedata[7:0]; m_ts = 0; bwr = 1'b1; end
               default: ;
            endcase
         end
         if (!bwr && tk) m_ts = m_ts + 1;
         m_segq = seg_in;
         m_k    = m_k + 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance n cycles, comparing hex_n with the model at every falling edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("hex_n", {25'd0, hex_n}, {25'd0, m_hex});
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cyc(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      chk(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic count_lit(input int n, output int lit_cnt);
      lit_cnt = 0;
      repeat (n) begin
         cyc(1);
         if (hex_n == 7'h40) lit_cnt++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      int c;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      seg_in     = 7'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // Reset state
      chk("reset_hex", {25'd0, hex_n}, 32'h7F);
      rd(2'd0, "reset_ctrl",   32'd5);
      rd(2'd1, "reset_bright", 32'd15);
      rd(2'd2, "reset_blink",  32'd2);
      rd(2'd3, "reset_status", m_read(2'd3));

      // Passthrough: digit 0, default (enabled, inverted) -> two-cycle latency
      seg_in = 7'h3F;
      cyc(1);
      chk("pass_1clk", {25'd0, hex_n}, 32'h7F);
      cyc(1);
      chk("pass_2clk", {25'd0, hex_n}, 32'h40);
      rd(2'd3, "status_seg", {25'd0, 7'h3F} | (readdata & 32'h300));
      chk("status_seg_bits", {25'd0, readdata[6:0]}, 32'h3F);

      // Polarity / enable
      wr(2'd0, 32'd1);
      chk("ctrl1_1clk", {25'd0, hex_n}, 32'h40);
      cyc(1);
      chk("ctrl1_2clk", {25'd0, hex_n}, 32'h3F);
      wr(2'd0, 32'd0);
      cyc(1);
      chk("ctrl0", {25'd0, hex_n}, 32'h00);
      wr(2'd0, 32'd4);
      cyc(1);
      chk("ctrl4", {25'd0, hex_n}, 32'h7F);

      // Blink with divider 2: 16-cycle period
      wr(2'd0, 32'd7);
      wr(2'd2, 32'd2);
      cyc(9);
      wr(2'd2, 32'd2);
      cyc(1);
      chk("blink_forced_visible", {25'd0, hex_n}, 32'h40);
      cyc(16);
      count_lit(32, c);
      chk("blink_div2_lit32", c, 16);
      count_lit(8, c);
      chk("blink_div2_lit8_not4", {31'd0, c != 4 || m_div != 8'd2}, 32'd1);

      // Blink divider 0 behaves as 1: 8-cycle period
      wr(2'd2, 32'd0);
      cyc(8);
      count_lit(8, c);
      chk("blink_div0_lit8", c, 4);
      count_lit(8, c);
      chk("blink_div0_lit8b", c, 4);

      // PWM dimming, no blink
      wr(2'd0, 32'd5);
      wr(2'd1, 32'd4);
      cyc(2);
      count_lit(16, c);
      chk("pwm_duty4", c, 4);
      wr(2'd1, 32'd0);
      cyc(2);
      count_lit(16, c);
      chk("pwm_duty0", c, 0);
      wr(2'd1, 32'd15);
      cyc(2);
      count_lit(16, c);
      chk("pwm_duty15", c, 16);

      // BLINK_DIV write coinciding with a tick
      wr(2'd0, 32'd7);
      for (int i = 0; i < 8 && (m_k % TICK) != (TICK - 1); i++) cyc(1);
      wr(2'd2, 32'd0);
      rd(2'd3, "status_tick_wr", m_read(2'd3));
      chk("status_phase_after_wr", {31'd0, readdata[8]}, 32'd1);

      // STATUS is read-only
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd0, "ro_ctrl",   32'd7);
      rd(2'd1, "ro_bright", 32'd15);
      rd(2'd2, "ro_blink",  32'd0);

      // Asynchronous reset mid-run
      cyc(3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_hex", {25'd0, hex_n}, 32'h7F);
      rd(2'd0, "rst2_ctrl",   32'd5);
      rd(2'd1, "rst2_bright", 32'd15);
      rd(2'd2, "rst2_blink",  32'd2);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(2);

      // Randomised traffic against the model
      for (int it = 0; it < 400; it++) begin
         int r;
         logic [1:0] a;
         r = $urandom_range(0, 9);
         a = 2'($urandom_range(0, 3));
         if (r < 3) begin
            if (a == 2'd2) wr(a, $urandom_range(0, 3));
            else           wr(a, $urandom);
         end else if (r < 5) begin
            seg_in = 7'($urandom);
            cyc(1);
         end else if (r < 7) begin
            rd(a, "rand_read", m_read(a));
            cyc(1);
         end else begin
            cyc($urandom_range(1, 6));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
